// File: rtl/ble_pkg.sv
// Shared constants, state encoding and whitening helpers for the BLE 1M packet transmitter.
package ble_pkg;

  localparam int unsigned PDU_LEN_MAX  = 39;
  localparam int unsigned PREAMBLE_LEN = 8;
  localparam int unsigned ACC_ADDR_LEN = 32;
  localparam int unsigned CRC_LEN      = 24;
  localparam int unsigned LEN_W        = 6;
  localparam int unsigned CNT_W        = 9;
  localparam int unsigned WHITE_W      = 7;

  localparam logic [CRC_LEN-1:0] CRC_POLY = 24'h00065B;
  localparam logic [CRC_LEN-1:0] CRC_INIT = 24'h555555;

  localparam logic [7:0] PREAMBLE_AA = 8'hAA;
  localparam logic [7:0] PREAMBLE_55 = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_ACCESS,
    ST_PDU,
    ST_CRC
  } state_t;

  // Channel index bit-reversed into w[6:1], w[0] forced to 1.
  function automatic logic [WHITE_W-1:0] whiten_seed(input logic [LEN_W-1:0] ch);
    return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
  endfunction

  function automatic logic [WHITE_W-1:0] whiten_next(input logic [WHITE_W-1:0] w);
    return {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
  endfunction

endpackage

// File: rtl/ble_crc24.sv
// Serial CRC24 register: preset, one-bit-per-cycle update, and MSB-first shift-out.
module ble_crc24
  import ble_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic preset,
  input  logic bit_en,
  input  logic bit_in,
  input  logic shift_en,
  output logic msb
);

  logic [CRC_LEN-1:0] crc_q;
  logic               fb;

  assign fb  = crc_q[CRC_LEN-1] ^ bit_in;
  assign msb = crc_q[CRC_LEN-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else if (preset) begin
      crc_q <= CRC_INIT;
    end else if (bit_en) begin
      crc_q <= {crc_q[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end else if (shift_en) begin
      crc_q <= {crc_q[CRC_LEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ble_packet_tx.sv
// BLE 1M uncoded packet serialiser: preamble, access address, PDU and CRC24, one bit per symbol tick.
// Define BLE_TX_WHITEN_EN to whiten PDU and CRC bits; otherwise they go out raw.
module ble_packet_tx
  import ble_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             symbol_tick,
  input  logic             start,
  input  logic [31:0]      acc_addr,
  input  logic [LEN_W-1:0] channel,
  input  logic [LEN_W-1:0] pdu_len,
  input  logic [7:0]       pdu_data,
  input  logic             pdu_valid,
  output logic             pdu_ready,
  output logic             symbol_out,
  output logic             symbol_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc, pdu_last;
  logic [LEN_W-1:0]   len_q, len_d, fetched_q, fetched_d;
  logic [31:0]        aa_q, aa_d;
  logic [7:0]         sr_q, sr_d, buf_q, buf_d, preamble;
  logic               full_q, full_d;
  logic               busy_d, valid_d, so_d, done_d, err_d, ready_d;
  logic               len_ok, byte_load, underrun, pdu_emit, crc_emit, raw_bit;
  logic               crc_preset, crc_bit_en, crc_shift, crc_msb;
  logic               wbit, seed_load, white_adv;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign pdu_last = {len_q, 3'b000} - CNT_W'(1);
  assign preamble = aa_q[0] ? PREAMBLE_55 : PREAMBLE_AA;
  assign len_ok   = (pdu_len >= LEN_W'(2)) && (pdu_len <= LEN_W'(PDU_LEN_MAX));

  ble_crc24 u_crc (
    .clk      (clk),
    .rst      (rst),
    .preset   (crc_preset),
    .bit_en   (crc_bit_en),
    .bit_in   (raw_bit),
    .shift_en (crc_shift),
    .msb      (crc_msb)
  );

`ifdef BLE_TX_WHITEN_EN
  logic [WHITE_W-1:0] w_q, w_d;

  always_comb begin
    w_d = w_q;
    if (seed_load)      w_d = whiten_seed(channel);
    else if (white_adv) w_d = whiten_next(w_q);
  end

  always_ff @(posedge clk) begin
    if (rst) w_q <= '0;
    else     w_q <= w_d;
  end

  assign wbit = w_q[WHITE_W-1];
`else
  logic unused_white;
  assign unused_white = ^{channel, seed_load, white_adv};
  assign wbit         = 1'b0;
`endif

  // Next-state and output decode; every symbol change is qualified by symbol_tick.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    aa_d       = aa_q;
    sr_d       = sr_q;
    buf_d      = buf_q;
    full_d     = full_q;
    fetched_d  = fetched_q;
    busy_d     = busy;
    valid_d    = symbol_valid;
    so_d       = symbol_out;
    done_d     = 1'b0;
    err_d      = 1'b0;
    seed_load  = 1'b0;
    white_adv  = 1'b0;
    crc_preset = 1'b0;
    crc_bit_en = 1'b0;
    crc_shift  = 1'b0;
    byte_load  = 1'b0;
    underrun   = 1'b0;
    pdu_emit   = 1'b0;
    crc_emit   = 1'b0;
    raw_bit    = 1'b0;

    if (pdu_valid && pdu_ready) begin
      buf_d     = pdu_data;
      full_d    = 1'b1;
      fetched_d = fetched_q + LEN_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d    = ST_PREAMBLE;
            len_d      = pdu_len;
            aa_d       = acc_addr;
            cnt_d      = '0;
            fetched_d  = '0;
            full_d     = 1'b0;
            busy_d     = 1'b1;
            valid_d    = 1'b0;
            so_d       = 1'b0;
            seed_load  = 1'b1;
            crc_preset = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PREAMBLE: begin
        if (symbol_tick) begin
          if (!symbol_valid) begin
            valid_d = 1'b1;
            so_d    = preamble[0];
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
            so_d    = aa_q[0];
          end else begin
            cnt_d = cnt_inc;
            so_d  = preamble[cnt_inc[2:0]];
          end
        end
      end
      ST_ACCESS: begin
        if (symbol_tick) begin
          if (cnt_q == CNT_W'(ACC_ADDR_LEN - 1)) begin
            if (full_q) begin
              state_d   = ST_PDU;
              cnt_d     = '0;
              byte_load = 1'b1;
            end else begin
              underrun = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
            so_d  = aa_q[cnt_inc[4:0]];
          end
        end
      end
      ST_PDU: begin
        if (symbol_tick) begin
          if (cnt_q == pdu_last) begin
            state_d  = ST_CRC;
            cnt_d    = '0;
            crc_emit = 1'b1;
          end else if (cnt_q[2:0] == 3'd7) begin
            if (full_q) begin
              cnt_d     = cnt_inc;
              byte_load = 1'b1;
            end else begin
              underrun = 1'b1;
            end
          end else begin
            cnt_d    = cnt_inc;
            pdu_emit = 1'b1;
            raw_bit  = sr_q[0];
            sr_d     = {1'b0, sr_q[7:1]};
          end
        end
      end
      ST_CRC: begin
        if (symbol_tick) begin
          if (cnt_q == CNT_W'(CRC_LEN - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            so_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d    = cnt_inc;
            crc_emit = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Byte boundary: buffered byte becomes the shift register, its bit 0 goes out now.
    if (byte_load) begin
      pdu_emit = 1'b1;
      raw_bit  = buf_q[0];
      sr_d     = {1'b0, buf_q[7:1]};
      full_d   = 1'b0;
    end
    if (underrun) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      so_d    = 1'b0;
      full_d  = 1'b0;
      err_d   = 1'b1;
    end
    if (pdu_emit) begin
      so_d       = raw_bit ^ wbit;
      crc_bit_en = 1'b1;
      white_adv  = 1'b1;
    end
    if (crc_emit) begin
      so_d      = crc_msb ^ wbit;
      crc_shift = 1'b1;
      white_adv = 1'b1;
    end

    ready_d = busy_d && !full_d && (fetched_d < len_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      aa_q         <= '0;
      sr_q         <= '0;
      buf_q        <= '0;
      full_q       <= 1'b0;
      fetched_q    <= '0;
      busy         <= 1'b0;
      symbol_valid <= 1'b0;
      symbol_out   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      pdu_ready    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      aa_q         <= aa_d;
      sr_q         <= sr_d;
      buf_q        <= buf_d;
      full_q       <= full_d;
      fetched_q    <= fetched_d;
      busy         <= busy_d;
      symbol_valid <= valid_d;
      symbol_out   <= so_d;
      done         <= done_d;
      err          <= err_d;
      pdu_ready    <= ready_d;
    end
  end

endmodule

// File: tb/tb_ble_packet_tx.sv
// Self-checking bench for ble_packet_tx: randomized packets against a behavioural bit-stream model.
module tb_ble_packet_tx;

`ifdef BLE_TX_WHITEN_EN
  localparam bit WHITE_ON = 1'b1;
`else
  localparam bit WHITE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        symbol_tick;
  logic        start;
  logic [31:0] acc_addr;
  logic [5:0]  channel;
  logic [5:0]  pdu_len;
  logic [7:0]  pdu_data;
  logic        pdu_valid;
  logic        pdu_ready;
  logic        symbol_out;
  logic        symbol_valid;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  int          tick_div = 0;
  int          feed_idx = 0;
  int          feed_limit = 0;
  logic [7:0]  feed_mem [64];
  logic [31:0] cur_aa;
  logic [5:0]  cur_ch;
  int          cur_len;
  bit          sym_q [$];
  bit          exp_q [$];
  logic [23:0] exp_crc;
  bit          exp_wcrc [24];
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          align_bad = 0;

  ble_packet_tx dut (
    .clk          (clk),
    .rst          (rst),
    .symbol_tick  (symbol_tick),
    .start        (start),
    .acc_addr     (acc_addr),
    .channel      (channel),
    .pdu_len      (pdu_len),
    .pdu_data     (pdu_data),
    .pdu_valid    (pdu_valid),
    .pdu_ready    (pdu_ready),
    .symbol_out   (symbol_out),
    .symbol_valid (symbol_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Symbol strobe every 4th cycle and the PDU byte source, both driven on the falling edge.
  initial begin
    symbol_tick = 1'b0;
    pdu_valid   = 1'b0;
    pdu_data    = 8'h00;
    forever begin
      @(negedge clk);
      tick_div++;
      symbol_tick = (tick_div % 4 == 0);
      pdu_valid   = (feed_idx < feed_limit);
      pdu_data    = (feed_idx < 64) ? feed_mem[feed_idx] : 8'h00;
    end
  end

  initial forever begin
    @(posedge clk);
    if (pdu_valid === 1'b1 && pdu_ready === 1'b1) feed_idx++;
  end

  // Output monitor: records one symbol per tick and flags changes off tick cycles.
  initial begin : monitor
    bit t, r;
    logic prev_so, prev_sv;
    prev_so = 1'b0;
    prev_sv = 1'b0;
    forever begin
      @(posedge clk);
      t = symbol_tick;
      r = rst;
      #1;
      if (t && symbol_valid === 1'b1) sym_q.push_back(symbol_out);
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
      if (!t && !r && (symbol_out !== prev_so || symbol_valid !== prev_sv)) align_bad++;
      prev_so = symbol_out;
      prev_sv = symbol_valid;
    end
  end

  // Expected bit stream built directly from the packet rules.
  task automatic build_expected();
    logic [7:0]  pre;
    logic [23:0] c;
    logic [6:0]  w;
    logic        b, o, fb;
    exp_q.delete();
    pre = cur_aa[0] ? 8'h55 : 8'hAA;
    for (int i = 0; i < 8; i++) exp_q.push_back(pre[i]);
    for (int i = 0; i < 32; i++) exp_q.push_back(cur_aa[i]);
    c = 24'h555555;
    w = {cur_ch[0], cur_ch[1], cur_ch[2], cur_ch[3], cur_ch[4], cur_ch[5], 1'b1};
    for (int k = 0; k < cur_len; k++) begin
      for (int i = 0; i < 8; i++) begin
        b = feed_mem[k][i];
        o = w[6];
        w = {w[5:0], o};
        w[4] = w[4] ^ o;
        exp_q.push_back(b ^ (WHITE_ON & o));
        fb = c[23] ^ b;
        c = {c[22:0], 1'b0};
        if (fb) c = c ^ 24'h00065B;
      end
    end
    exp_crc = c;
    for (int i = 0; i < 24; i++) begin
      o = w[6];
      w = {w[5:0], o};
      w[4] = w[4] ^ o;
      exp_wcrc[i] = WHITE_ON & o;
      exp_q.push_back(c[23 - i] ^ exp_wcrc[i]);
    end
  endtask

  function automatic int first_diff(int n);
    for (int i = 0; i < n; i++) begin
      if (i >= sym_q.size() || i >= exp_q.size()) return i;
      if (sym_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 64; k++) feed_mem[k] = 8'($urandom);
  endtask

  task automatic start_packet(input logic [31:0] aa, input logic [5:0] ch, input int len,
                              input int limit, input bit align);
    @(negedge clk);
    #1;
    cur_aa = aa;
    cur_ch = ch;
    cur_len = len;
    feed_idx = 0;
    feed_limit = limit;
    sym_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    if (align) begin
      for (int i = 0; i < 8; i++) begin
        if ((tick_div + 1) % 4 == 0) break;
        @(negedge clk);
        #1;
      end
    end
    @(negedge clk);
    acc_addr = aa;
    channel  = ch;
    pdu_len  = 6'(len);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      if (done_cnt + err_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #2;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done/err, expected one within 4000 cycles", name);
    end
  endtask

  task automatic wait_symbols(input int n, input string name);
    int i;
    for (i = 0; i < 4000 && sym_q.size() < n; i++) @(posedge clk);
    total++;
    if (sym_q.size() < n) begin
      bad++;
      $display("FAIL %s_wait: got %0d symbols, expected at least %0d", name, sym_q.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {symbol_out, symbol_valid, busy, done, err, pdu_ready};
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected 000000", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {symbol_out, symbol_valid, busy, done, err, pdu_ready};
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("FAIL idle_outputs: got %b expected 000000", obs);
    end
  endtask

  task automatic test_preamble_access();
    logic [7:0]  pre_obs;
    logic [31:0] aa_obs;
    int d;
    fill_random();
    start_packet(32'h6b7d9171, 6'd37, 2, 2, 1'b0);
    wait_end("pa");
    build_expected();
    for (int i = 0; i < 8; i++) pre_obs[i] = (i < sym_q.size()) ? sym_q[i] : 1'bx;
    for (int i = 0; i < 32; i++) aa_obs[i] = (i + 8 < sym_q.size()) ? sym_q[i + 8] : 1'bx;
    total++;
    if (pre_obs !== 8'h55) begin
      bad++;
      $display("FAIL pa_preamble: got %h expected 55", pre_obs);
    end
    total++;
    if (aa_obs !== 32'h6b7d9171) begin
      bad++;
      $display("FAIL pa_access: got %h expected 6b7d9171", aa_obs);
    end
    total++;
    if (sym_q.size() !== 80) begin
      bad++;
      $display("FAIL pa_count: got %0d expected 80", sym_q.size());
    end
    d = first_diff(exp_q.size());
    total++;
    if (d !== -1) begin
      bad++;
      $display("FAIL pa_bits: first wrong symbol at %0d, expected none", d);
    end
    total++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      bad++;
      $display("FAIL pa_done: got done=%0d err=%0d expected done=1 err=0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_whitening();
    logic [23:0] crc_obs;
    bit exp_first;
    int d;
    feed_mem[0] = 8'h40;
    feed_mem[1] = 8'h00;
    start_packet($urandom, 6'd37, 2, 2, 1'b0);
    wait_end("wh");
    build_expected();
    exp_first = WHITE_ON ? cur_ch[0] : feed_mem[0][0];
    total++;
    if (sym_q.size() < 80 || sym_q[40] !== exp_first) begin
      bad++;
      $display("FAIL wh_first_pdu_bit: got %0d expected %0d",
               (sym_q.size() > 40) ? int'(sym_q[40]) : -1, exp_first);
    end
    for (int i = 0; i < 24; i++)
      crc_obs[23 - i] = (56 + i < sym_q.size()) ? (sym_q[56 + i] ^ exp_wcrc[i]) : 1'bx;
    total++;
    if (crc_obs !== exp_crc) begin
      bad++;
      $display("FAIL wh_crc24: got %h expected %h", crc_obs, exp_crc);
    end
    d = first_diff(exp_q.size());
    total++;
    if (d !== -1 || sym_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL wh_bits: first wrong symbol at %0d (got %0d symbols, expected %0d)",
               d, sym_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    int len, d;
    for (int n = 0; n < 4; n++) begin
      fill_random();
      len = $urandom_range(2, 39);
      start_packet($urandom, 6'($urandom_range(0, 39)), len, len, 1'b0);
      wait_end("rnd");
      build_expected();
      d = first_diff(exp_q.size());
      total++;
      if (d !== -1 || sym_q.size() !== 64 + 8 * len) begin
        bad++;
        $display("FAIL rnd_bits[%0d]: len=%0d first wrong at %0d, got %0d symbols expected %0d",
                 n, len, d, sym_q.size(), 64 + 8 * len);
      end
      total++;
      if (done_cnt !== 1 || err_cnt !== 0) begin
        bad++;
        $display("FAIL rnd_done[%0d]: got done=%0d err=%0d expected done=1 err=0", n, done_cnt, err_cnt);
      end
    end
  endtask

  task automatic test_underrun();
    int d;
    fill_random();
    start_packet($urandom, 6'($urandom_range(0, 39)), 4, 2, 1'b0);
    wait_end("ur");
    build_expected();
    total++;
    if (err_cnt !== 1 || done_cnt !== 0) begin
      bad++;
      $display("FAIL ur_pulses: got err=%0d done=%0d expected err=1 done=0", err_cnt, done_cnt);
    end
    total++;
    if (sym_q.size() !== 56) begin
      bad++;
      $display("FAIL ur_count: got %0d expected 56", sym_q.size());
    end
    d = first_diff(56);
    total++;
    if (d !== -1) begin
      bad++;
      $display("FAIL ur_prefix: first wrong symbol at %0d, expected none", d);
    end
    total++;
    if (symbol_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ur_idle: got valid=%b busy=%b expected 0 0", symbol_valid, busy);
    end
    feed_limit = 0;
  endtask

  task automatic test_reject();
    int lens [2];
    lens[0] = 1;
    lens[1] = 40;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      acc_addr = $urandom;
      channel  = 6'd5;
      pdu_len  = 6'(lens[n]);
      start    = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rej_len%0d: got err=%b busy=%b expected err=1 busy=0", lens[n], err, busy);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (err !== 1'b0 || busy !== 1'b0 || symbol_valid !== 1'b0) begin
        bad++;
        $display("FAIL rej_after%0d: got err=%b busy=%b valid=%b expected 0 0 0",
                 lens[n], err, busy, symbol_valid);
      end
    end
  endtask

  task automatic test_start_ignored();
    int d;
    fill_random();
    start_packet($urandom, 6'($urandom_range(0, 39)), 6, 6, 1'b0);
    wait_symbols(48, "ign");
    @(negedge clk);
    acc_addr = ~cur_aa;
    channel  = 6'd0;
    pdu_len  = 6'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("ign");
    build_expected();
    d = first_diff(exp_q.size());
    total++;
    if (d !== -1 || sym_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL ign_bits: first wrong at %0d, got %0d symbols expected %0d", d, sym_q.size(), exp_q.size());
    end
    total++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      bad++;
      $display("FAIL ign_done: got done=%0d err=%0d expected done=1 err=0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_start_on_tick();
    int len, d;
    fill_random();
    len = $urandom_range(2, 8);
    start_packet($urandom, 6'($urandom_range(0, 39)), len, len, 1'b1);
    #1;
    total++;
    if (busy !== 1'b1 || symbol_valid !== 1'b0) begin
      bad++;
      $display("FAIL tick_start: got busy=%b valid=%b expected busy=1 valid=0", busy, symbol_valid);
    end
    wait_end("tick");
    build_expected();
    d = first_diff(exp_q.size());
    total++;
    if (d !== -1 || sym_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL tick_bits: first wrong at %0d, got %0d symbols expected %0d", d, sym_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] obs;
    int len, d;
    fill_random();
    start_packet($urandom, 6'($urandom_range(0, 39)), 5, 5, 1'b0);
    wait_symbols(20, "rstmid");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    obs = {symbol_out, symbol_valid, busy, done, err, pdu_ready};
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("FAIL rstmid_outputs: got %b expected 000000", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (done_cnt !== 0 || err_cnt !== 0) begin
      bad++;
      $display("FAIL rstmid_pulses: got done=%0d err=%0d expected 0 0", done_cnt, err_cnt);
    end
    fill_random();
    len = $urandom_range(2, 39);
    start_packet($urandom, 6'($urandom_range(0, 39)), len, len, 1'b0);
    wait_end("rstnew");
    build_expected();
    d = first_diff(exp_q.size());
    total++;
    if (d !== -1 || sym_q.size() !== exp_q.size() || done_cnt !== 1) begin
      bad++;
      $display("FAIL rstmid_fresh: first wrong at %0d, got %0d symbols done=%0d expected %0d symbols done=1",
               d, sym_q.size(), done_cnt, exp_q.size());
    end
  endtask

  task automatic test_alignment();
    total++;
    if (align_bad !== 0) begin
      bad++;
      $display("FAIL tick_only_changes: got %0d off-tick output changes expected 0", align_bad);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    acc_addr = '0;
    channel  = '0;
    pdu_len  = '0;
    for (int k = 0; k < 64; k++) feed_mem[k] = 8'h00;
    test_reset();
    test_preamble_access();
    test_whitening();
    test_random();
    test_underrun();
    test_reject();
    test_start_ignored();
    test_start_on_tick();
    test_reset_mid();
    test_alignment();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
